imm_pack: RTL and testbench

Immediate packer: the inverse of the datapath immediate extender. It takes a 32-bit constant and searches the four extension modes (EOp 00 sign, 01 zero, 10 upper/LUI, 11 sign-shifted-by-2 branch offset) for a 16-bit immediate that re-extends to exactly that constant. It returns the immediate, the EOp that reproduces it, and a fit flag. It sits in the instruction-generation path (assembler/encoder helper and self-check harness), and uses valid/ready handshakes on both sides.

---
 rtl/imm_pack.sv | 133 +++++++++++++
 tb/tb_imm_pack.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_pack.sv
// imm_pack: searches the four immediate-extension modes for a 16-bit immediate
// that re-extends to a given 32-bit value. Optional result counters under IMM_PACK_STATS_EN.
module imm_pack #(
  parameter logic [3:0] MODE_MASK = 4'b1111,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      imm,
  output logic [1:0]       eop,
  output logic             fit,
  output logic [CNT_W-1:0] pack_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {IDLE, TRY, DONE} state_t;

  state_t       state_reg, state_next;
  logic [31:0]  value_reg, value_next;
  logic [1:0]   mode_reg, mode_next;
  logic [15:0]  imm_reg, imm_next;
  logic [1:0]   eop_reg, eop_next;
  logic         fit_reg, fit_next;
  logic [3:0]   raw_match, match;
  logic [3:0][15:0] cand;

  always_comb begin
    raw_match[0] = (value_reg[31:16] == {16{value_reg[15]}});
    raw_match[1] = (value_reg[31:16] == 16'h0000);
    raw_match[2] = (value_reg[15:0] == 16'h0000);
    raw_match[3] = (value_reg[1:0] == 2'b00) && (value_reg[31:18] == {14{value_reg[17]}});
    cand[0]      = value_reg[15:0];
    cand[1]      = value_reg[15:0];
    cand[2]      = value_reg[31:16];
    cand[3]      = value_reg[17:2];
  end

  // A masked-off mode still takes its cycle in TRY; it just can never hit.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign match[gi] = raw_match[gi] & MODE_MASK[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      value_reg <= '0;
      mode_reg  <= '0;
      imm_reg   <= '0;
      eop_reg   <= '0;
      fit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      value_reg <= value_next;
      mode_reg  <= mode_next;
      imm_reg   <= imm_next;
      eop_reg   <= eop_next;
      fit_reg   <= fit_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    value_next = value_reg;
    mode_next  = mode_reg;
    imm_next   = imm_reg;
    eop_next   = eop_reg;
    fit_next   = fit_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          value_next = value;
          mode_next  = 2'd0;
          state_next = TRY;
        end
      end
      TRY: begin
        if (match[mode_reg]) begin
          imm_next   = cand[mode_reg];
          eop_next   = mode_reg;
          fit_next   = 1'b1;
          state_next = DONE;
        end else if (mode_reg == 2'd3) begin
          imm_next   = 16'h0000;
          eop_next   = 2'd0;
          fit_next   = 1'b0;
          state_next = DONE;
        end else begin
          mode_next = mode_reg + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs read as zero for the whole time reset is held, not just after its first edge.
  assign in_ready  = (state_reg == IDLE) && !reset;
  assign out_valid = (state_reg == DONE) && !reset;
  assign imm       = reset ? 16'h0000 : imm_reg;
  assign eop       = reset ? 2'd0 : eop_reg;
  assign fit       = fit_reg && !reset;

`ifdef IMM_PACK_STATS_EN
  logic             out_hs;
  logic [CNT_W-1:0] pack_cnt_reg, miss_cnt_reg;

  assign out_hs = (state_reg == DONE) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      pack_cnt_reg <= '0;
      miss_cnt_reg <= '0;
    end else if (out_hs) begin
      if (fit_reg && !(&pack_cnt_reg))  pack_cnt_reg <= pack_cnt_reg + 1'b1;
      if (!fit_reg && !(&miss_cnt_reg)) miss_cnt_reg <= miss_cnt_reg + 1'b1;
    end
  end

  assign pack_cnt = reset ? '0 : pack_cnt_reg;
  assign miss_cnt = reset ? '0 : miss_cnt_reg;
`else
  assign pack_cnt = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_pack.sv
// Bench for imm_pack: directed vector table, randomized values against an
// arithmetic reference model, back-pressure and reset corner sequences.
module tb_imm_pack;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      value;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      imm;
  logic [1:0]       eop;
  logic             fit;
  logic [CNT_W-1:0] pack_cnt;
  logic [CNT_W-1:0] miss_cnt;

  int checks = 0;
  int fails  = 0;
  int pack_exp = 0;
  int miss_exp = 0;

  always #5 clk = ~clk;

  imm_pack #(.MODE_MASK(4'b1111), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .value(value), .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .eop(eop), .fit(fit), .pack_cnt(pack_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct packed {
    logic [31:0] v;
    logic [15:0] imm;
    logic [1:0]  eop;
    logic        fit;
    logic [2:0]  k;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: decide each mode from the numeric range the extender can produce.
  function automatic void ref_pack(input logic [31:0] v, output logic [15:0] ri,
                                   output logic [1:0] re, output logic rf, output int rk);
    longint s = longint'($signed(v));
    longint u = longint'(v);
    ri = 16'h0; re = 2'd0; rf = 1'b0; rk = 4;
    if (s >= -32768 && s <= 32767) begin
      ri = 16'(s); re = 2'd0; rf = 1'b1; rk = 1;
    end else if (u < 65536) begin
      ri = 16'(u); re = 2'd1; rf = 1'b1; rk = 2;
    end else if (u % 65536 == 0) begin
      ri = 16'(u / 65536); re = 2'd2; rf = 1'b1; rk = 3;
    end else if (u % 4 == 0 && s >= -131072 && s <= 131071) begin
      ri = 16'(s / 4); re = 2'd3; rf = 1'b1; rk = 4;
    end
  endfunction

  function automatic int cnt_view(input int c);
`ifdef IMM_PACK_STATS_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_pack_cnt"}, 32'(pack_cnt), 32'(cnt_view(pack_exp)));
    check({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(cnt_view(miss_exp)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {in_ready, out_valid, imm, eop, fit}, 32'h0);
    check_counters("rst");
    pack_exp = 0; miss_exp = 0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", in_ready, 1);
  endtask

  task automatic run_txn(input logic [31:0] v, input logic [15:0] ei, input logic [1:0] ee,
                         input logic ef, input int ek, input int hold, input bit early);
    int n;
    bit seen;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; value = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = early;
    seen = 1'b0;
    for (n = 0; n < 8; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      // Stray traffic while busy must not disturb the captured value.
      in_valid = 1'($urandom); value = $urandom;
    end
    in_valid = 1'b0;
    if (!seen) begin
      checks++; fails++;
      $display("FAIL timeout: value 0x%08h got no out_valid, expected after E0+%0d", v, ek);
      do_reset();
      return;
    end
    $display("txn value=0x%08h imm=0x%04h eop=%0d fit=%0d k=%0d", v, imm, eop, fit, n);
    check("latency", n, ek);
    check("imm", imm, ei);
    check("eop", eop, ee);
    check("fit", fit, ef);
    check("done_in_ready", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      value = $urandom;
      @(negedge clk);
      check("hold_stable", {out_valid, in_ready, imm, eop, fit}, {1'b1, 1'b0, ei, ee, ef});
    end
    out_ready = 1'b1;
    @(posedge clk);
    if (ef) pack_exp = (pack_exp < CNT_MAX) ? pack_exp + 1 : pack_exp;
    else    miss_exp = (miss_exp < CNT_MAX) ? miss_exp + 1 : miss_exp;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs", {out_valid, in_ready}, 32'h1);
    check_counters("hs");
  endtask

  task automatic run_model(input logic [31:0] v, input int hold, input bit early);
    logic [15:0] ri; logic [1:0] re; logic rf; int rk;
    ref_pack(v, ri, re, rf, rk);
    run_txn(v, ri, re, rf, rk, hold, early);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, v;
    int bad;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; value = 32'h0;

    vecs[0] = '{32'h0000_0005, 16'h0005, 2'd0, 1'b1, 3'd1};
    vecs[1] = '{32'h0000_FFFF, 16'hFFFF, 2'd1, 1'b1, 3'd2};
    vecs[2] = '{32'hFFFF_8000, 16'h8000, 2'd0, 1'b1, 3'd1};
    vecs[3] = '{32'h1234_0000, 16'h1234, 2'd2, 1'b1, 3'd3};
    vecs[4] = '{32'h0001_2344, 16'h48D1, 2'd3, 1'b1, 3'd4};
    vecs[5] = '{32'h1234_5678, 16'h0000, 2'd0, 1'b0, 3'd4};
    vecs[6] = '{32'h0000_0000, 16'h0000, 2'd0, 1'b1, 3'd1};
    vecs[7] = '{32'hFFFE_0000, 16'hFFFE, 2'd2, 1'b1, 3'd3};
    vecs[8] = '{32'hFFFE_0004, 16'h8001, 2'd3, 1'b1, 3'd4};

    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, out_valid, imm, eop, fit}, 32'h0);
    check_counters("reset");
    reset = 1'b0;
    @(negedge clk);
    check("reset_release_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++)
      run_txn(vecs[i].v, vecs[i].imm, vecs[i].eop, vecs[i].fit, int'(vecs[i].k), 0, 1'b0);

    // Back-pressure: result held for 10 cycles with out_ready low.
    run_txn(32'h0001_2344, 16'h48D1, 2'd3, 1'b1, 4, 10, 1'b0);

    // out_ready high while idle and during TRY is ignored.
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_out_ready_ignored", {out_valid, in_ready}, 32'h1);
    out_ready = 1'b0;
    run_txn(32'h1234_0000, 16'h1234, 2'd2, 1'b1, 3, 0, 1'b1);

    // Randomized values biased toward each mode's range.
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      case ($urandom_range(0, 4))
        0: v = {{16{r[15]}}, r[15:0]};
        1: v = {16'h0000, r[15:0]};
        2: v = {r[31:16], 16'h0000};
        3: v = {{14{r[17]}}, r[17:2], 2'b00};
        default: v = r;
      endcase
      run_model(v, $urandom_range(0, 2), 1'b0);
    end

    // Reset in TRY: the transaction is dropped.
    @(negedge clk);
    in_valid = 1'b1; value = 32'h1234_5678;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_try_outputs", {in_ready, out_valid, imm, eop, fit}, 32'h0);
    check_counters("rst_try");
    pack_exp = 0; miss_exp = 0;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad++;
    end
    check("rst_try_no_result", bad, 0);

    // Reset in DONE: pending result vanishes, counters clear.
    run_model(32'h0000_0005, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; value = 32'h0000_0007;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_done_valid", out_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_done_outputs", {in_ready, out_valid, imm, eop, fit}, 32'h0);
    check_counters("rst_done");
    pack_exp = 0; miss_exp = 0;
    reset = 1'b0;
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    out_ready = 1'b0;
    check("rst_done_no_result", bad, 0);
    check_counters("after_rst_done");

    // Counter saturation at CNT_W=2.
    for (int i = 0; i < 5; i++) run_model(32'h0000_0100 + 32'(i), 0, 1'b0);
    for (int i = 0; i < 5; i++) run_model(32'h1234_5679 + 32'(i), 0, 1'b0);
    check_counters("saturated");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
